// File: rtl/branch_pred_table.sv
// Direct-mapped branch target buffer with 2-bit hysteresis state per entry.
// Ports: CLK/RST, lkup_* (combinational predict), upd_* (resolve), clr, cnt_* stats.
module branch_pred_table #(
  parameter int BTAG_W = 22,
  parameter int BIND_W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] lkup_pc,
  output logic        lkup_hit,
  output logic        lkup_taken,
  output logic [31:0] lkup_target,
  output logic [1:0]  lkup_state,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_wstat,
  input  logic        clr,
  output logic [31:0] cnt_branch,
  output logic [31:0] cnt_mispred
);

  localparam int N = 1 << BIND_W;

  typedef enum logic [1:0] {
    NH = 2'b00,
    NS = 2'b01,
    TS = 2'b11,
    TH = 2'b10
  } branch_pred_state_t;

  logic               valid_q [N];
  logic [BTAG_W-1:0]  tag_q   [N];
  branch_pred_state_t state_q [N];
  logic [31:0]        tgt_q   [N];

  logic [31:0] cnt_branch_q, cnt_branch_d;
  logic [31:0] cnt_mispred_q, cnt_mispred_d;

  function automatic branch_pred_state_t step(
    input branch_pred_state_t s,
    input logic               t
  );
    case (s)
      NH:      step = t ? NS : NH;
      NS:      step = t ? TS : NH;
      TS:      step = t ? TH : NS;
      TH:      step = t ? TH : TS;
      default: step = NH;
    endcase
  endfunction

  // lookup path: reads stored contents only, no bypass of updates
  logic [BIND_W-1:0] l_idx;
  logic [BTAG_W-1:0] l_tag;
  logic              l_hit;

  assign l_idx = lkup_pc[2 +: BIND_W];
  assign l_tag = lkup_pc[BIND_W+2 +: BTAG_W];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  assign lkup_hit    = l_hit;
  assign lkup_state  = l_hit ? state_q[l_idx] : NH;
  assign lkup_taken  = l_hit && lkup_state[1];
  assign lkup_target = l_hit ? tgt_q[l_idx] : 32'h0;

  // update path
  logic [BIND_W-1:0]  u_idx;
  logic [BTAG_W-1:0]  u_tag;
  logic               u_hit;
  branch_pred_state_t u_next;
  logic               u_mis;

  assign u_idx  = upd_pc[2 +: BIND_W];
  assign u_tag  = upd_pc[BIND_W+2 +: BTAG_W];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_next = step(state_q[u_idx], upd_taken);

  // predicted-taken with a stale target is also a mispredict
  assign u_mis = (upd_wstat[1] != upd_taken) ||
                 (upd_wstat[1] && upd_taken && u_hit &&
                  (tgt_q[u_idx] != upd_target));

  always_comb begin
    cnt_branch_d  = cnt_branch_q;
    cnt_mispred_d = cnt_mispred_q;
    if (upd_en) begin
      cnt_branch_d = cnt_branch_q + 32'd1;
      if (u_mis)
        cnt_mispred_d = cnt_mispred_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        state_q[i] <= NH;
        tgt_q[i]   <= 32'h0;
      end
    end else if (clr) begin
      for (int i = 0; i < N; i++)
        valid_q[i] <= 1'b0;
    end else if (upd_en) begin
      if (u_hit) begin
        state_q[u_idx] <= u_next;
        if (upd_taken)
          tgt_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        state_q[u_idx] <= TS;
        tgt_q[u_idx]   <= upd_target;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_branch_q  <= 32'h0;
      cnt_mispred_q <= 32'h0;
    end else begin
      cnt_branch_q  <= cnt_branch_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

  assign cnt_branch  = cnt_branch_q;
  assign cnt_mispred = cnt_mispred_q;

  logic unused_bits;
  assign unused_bits = ^{lkup_pc[1:0], upd_pc[1:0], upd_wstat[0]};

endmodule

// File: doc/branch_pred_table.md
BRANCH_PRED_TABLE -- requirements
Module: branch_pred_table

Interface
REQ-001: The block SHALL have parameter BTAG_W, default 22, meaning tag width taken from PC[31:10].
REQ-002: The block SHALL have parameter BIND_W, default 8, meaning index width taken from PC[9:2], giving 256 entries.
REQ-003: The block SHALL have port CLK, input, 1 bit, the single clock, rising-edge active.
REQ-004: The block SHALL have port RST, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-005: The block SHALL have port lkup_pc, input, 32 bits, the fetch-stage PC to predict.
REQ-006: The block SHALL have port lkup_hit, output, 1 bit, meaning a valid entry matches the tag.
REQ-007: The block SHALL have port lkup_taken, output, 1 bit, the predicted-taken flag.
REQ-008: The block SHALL have port lkup_target, output, 32 bits, the predicted target.
REQ-009: The block SHALL have port lkup_state, output, 2 bits, the branch_pred_state_t sent down the pipe as wstat.
REQ-010: The block SHALL have port upd_en, input, 1 bit, meaning a resolved branch is present this cycle.
REQ-011: The block SHALL have port upd_pc, input, 32 bits, the resolved branch PC.
REQ-012: The block SHALL have port upd_taken, input, 1 bit, the actual branch outcome.
REQ-013: The block SHALL have port upd_target, input, 32 bits, the actual branch target (baddr).
REQ-014: The block SHALL have port upd_wstat, input, 2 bits, the lkup_state captured at fetch.
REQ-015: The block SHALL have port clr, input, 1 bit, a synchronous invalidate-all request.
REQ-016: The block SHALL have port cnt_branch, output, 32 bits, counting resolved branches.
REQ-017: The block SHALL have port cnt_mispred, output, 32 bits, counting mispredictions.

Function
REQ-018: Each entry SHALL hold valid, tag[BTAG_W], state[2] and target[32]; the entry index SHALL be pc[9:2], and pc[1:0] SHALL be ignored.
REQ-019: Lookup SHALL be combinational from the current array contents: lkup_hit = valid && tag match; lkup_state = hit ? state : NH(00); lkup_taken = lkup_hit && lkup_state[1]; lkup_target = hit ? target : 0.
REQ-020: A same-cycle update to the looked-up index SHALL NOT be visible on the lookup outputs until after the clock edge (no bypass).
REQ-021: State encoding SHALL be NH=00, NS=01, TS=11, TH=10.
- Taken transitions: NH->NS, NS->TS, TS->TH, TH->TH.
- Not-taken transitions: TH->TS, TS->NS, NS->NH, NH->NH.
REQ-022: On upd_en with an index/tag hit, the entry state SHALL step from its current stored state (not from upd_wstat), and on a taken outcome the target SHALL be overwritten with upd_target.
REQ-023: On upd_en with a miss and upd_taken=1, the entry SHALL be allocated (overwriting any alias) with valid=1, the new tag, state TS and upd_target.
REQ-024: On upd_en with a miss and upd_taken=0, the array SHALL be left unchanged.
REQ-025: On every upd_en, cnt_branch SHALL increment by 1.
REQ-026: cnt_mispred SHALL increment by 1 when upd_wstat[1] != upd_taken; it SHALL also increment when upd_wstat[1]=1, upd_taken=1 and the stored target (on a hit) differs from upd_target.
REQ-027: Counters SHALL wrap modulo 2^32.
REQ-028: clr SHALL clear all valid bits at the next edge; states, targets and counters SHALL be unaffected.
REQ-029: When clr and upd_en coincide, clr SHALL win for the array (the update is dropped) while the counters still update per REQ-025 and REQ-026.
REQ-030: Updates SHALL take effect at the edge ending the cycle in which upd_en=1, with a one-cycle latency to lookup visibility.

Reset
REQ-031: While RST=1, independent of CLK, all valid bits SHALL be 0, all states NH, all targets 0, and cnt_branch = cnt_mispred = 0.
REQ-032: Consequently, during and after reset, lkup_hit=0, lkup_taken=0, lkup_target=0 and lkup_state=00.
REQ-033: Assertion of RST mid-update SHALL discard the update, leaving no partial entry.

Verification
REQ-034: Reset, then lkup_pc=0x00000040 -> lkup_hit=0, lkup_state=00, lkup_target=0.
REQ-035: upd_en, upd_pc=0x40, upd_taken=1, upd_target=0x100, upd_wstat=00 -> next cycle lookup of 0x40 gives hit=1, state=11, taken=1, target=0x100; cnt_branch=1, cnt_mispred=1.
REQ-036: Four not-taken updates to 0x40 -> state walks 11->01->00->00; lkup_taken=0 after the first update.
REQ-037: An entry for 0x40 exists; a taken update of alias 0x440 (same index, different tag) -> lookup of 0x40 misses and lookup of 0x440 hits with state 11; a not-taken update of 0x840 leaves 0x440 intact.
REQ-038: Same-cycle lookup and update of 0x80 -> lookup shows the pre-update value; clr together with upd_en -> all lookups miss next cycle and cnt_branch still increments.
REQ-039: 2^32 wrap of cnt_branch (forced preload 0xFFFFFFFF) -> 0 after one update; RST pulsed between edges -> outputs clear immediately.
